// File: rtl/zap_tag_lookup_ctrl.sv
// zap_tag_lookup_ctrl: direct-mapped tag lookup, miss refill and flush sequencer
// for a tag RAM with 2-cycle read latency and single-cycle bulk invalidate.
module zap_tag_lookup_ctrl #(
    parameter int DEPTH = 32,
    parameter int LINE_BYTES = 16,
    localparam int OFF_W = $clog2(LINE_BYTES),
    localparam int IDX_W = $clog2(DEPTH),
    localparam int TAG_W = 32 - OFF_W - IDX_W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_req,
    input  logic [31:0]      i_addr,
    output logic             o_ready,
    output logic             o_done,
    output logic             o_hit,
    input  logic             i_flush,
    output logic             o_flush_done,
    output logic             o_fill_req,
    output logic [31:0]      o_fill_addr,
    input  logic             i_fill_ack,
    output logic             o_tag_clken,
    output logic [IDX_W-1:0] o_tag_raddr,
    output logic [IDX_W-1:0] o_tag_waddr,
    output logic [TAG_W-1:0] o_tag_wdata,
    output logic             o_tag_wen,
    output logic             o_tag_inv,
    input  logic [TAG_W-1:0] i_tag_rdata,
    input  logic             i_tag_rdav,
    output logic [31:0]      o_hit_cnt,
    output logic [31:0]      o_miss_cnt
);
    typedef enum logic [2:0] {IDLE, RD1, CMP, FILL, WR, FLUSH} state_t;
    state_t state, state_nx;
    logic [31:0] addr_q, hit_cnt, miss_cnt;
    logic [IDX_W-1:0] idx_q;
    logic [TAG_W-1:0] tag_q;
    logic hit;
    assign idx_q = addr_q[OFF_W +: IDX_W];
    assign tag_q = addr_q[31 -: TAG_W];
    assign hit = i_tag_rdav & (i_tag_rdata == tag_q);
    assign o_tag_clken = ~i_reset;
    assign o_hit_cnt = hit_cnt;
    assign o_miss_cnt = miss_cnt;
    always_ff @(posedge i_clk)
        if (i_reset) state <= IDLE;
        else state <= state_nx;
    // Counters saturate rather than wrap.
    always_ff @(posedge i_clk)
        if (i_reset) begin
            addr_q <= '0;
            hit_cnt <= '0;
            miss_cnt <= '0;
        end else begin
            if (state == IDLE && i_req && !i_flush) addr_q <= i_addr;
            if (state == CMP && hit && hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
            if (state == CMP && !hit && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
        end
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE: state_nx = i_flush ? FLUSH : i_req ? RD1 : IDLE;
            RD1: state_nx = CMP;
            CMP: state_nx = hit ? IDLE : FILL;
            FILL: state_nx = i_fill_ack ? WR : FILL;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        o_ready = state == IDLE && !i_flush;
        o_hit = state == CMP && hit;
        o_done = o_hit || state == WR;
        o_flush_done = state == FLUSH;
        o_tag_inv = state == FLUSH;
        o_fill_req = state == FILL;
        o_fill_addr = state == FILL ? addr_q & ~32'(LINE_BYTES - 1) : '0;
        o_tag_wen = state == WR;
        o_tag_waddr = state == WR ? idx_q : '0;
        o_tag_wdata = state == WR ? tag_q : '0;
        o_tag_raddr = state == IDLE ? i_addr[OFF_W +: IDX_W] : idx_q;
    end
endmodule

// File: tb/tb_zap_tag_lookup_ctrl.sv
// tb_zap_tag_lookup_ctrl: directed plus random lookups against a tag RAM model
// and an abstract cache-contents model with expected hit/miss counts.
module tb_zap_tag_lookup_ctrl;
    localparam int DEPTH = 32;
    localparam int LINE_BYTES = 16;
    localparam int OFF_W = 4;
    localparam int IDX_W = 5;
    localparam int TAG_W = 23;
    logic i_clk = 0, i_reset = 1, i_req = 0, i_flush = 0, i_fill_ack = 0;
    logic [31:0] i_addr = 0;
    logic o_ready, o_done, o_hit, o_flush_done, o_fill_req, o_tag_clken, o_tag_wen, o_tag_inv;
    logic [31:0] o_fill_addr, o_hit_cnt, o_miss_cnt;
    logic [IDX_W-1:0] o_tag_raddr, o_tag_waddr, ra1;
    logic [TAG_W-1:0] o_tag_wdata, rd_tag;
    logic rd_v;
    logic [TAG_W-1:0] ram_t [DEPTH];
    logic ram_v [DEPTH];
    logic [TAG_W-1:0] mt [DEPTH];
    bit mv [DEPTH];
    logic [31:0] exp_hits, exp_miss;
    int total, bad;

    zap_tag_lookup_ctrl #(.DEPTH(DEPTH), .LINE_BYTES(LINE_BYTES)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .i_addr(i_addr),
        .o_ready(o_ready), .o_done(o_done), .o_hit(o_hit), .i_flush(i_flush),
        .o_flush_done(o_flush_done), .o_fill_req(o_fill_req), .o_fill_addr(o_fill_addr),
        .i_fill_ack(i_fill_ack), .o_tag_clken(o_tag_clken), .o_tag_raddr(o_tag_raddr),
        .o_tag_waddr(o_tag_waddr), .o_tag_wdata(o_tag_wdata), .o_tag_wen(o_tag_wen),
        .o_tag_inv(o_tag_inv), .i_tag_rdata(rd_tag), .i_tag_rdav(rd_v),
        .o_hit_cnt(o_hit_cnt), .o_miss_cnt(o_miss_cnt)
    );

    always #5 i_clk = ~i_clk;

    // Tag RAM: registered address and registered data, so data follows raddr by 2 cycles.
    always @(posedge i_clk) begin
        if (o_tag_inv) for (int k = 0; k < DEPTH; k++) ram_v[k] <= 1'b0;
        if (o_tag_wen) begin
            ram_t[o_tag_waddr] <= o_tag_wdata;
            ram_v[o_tag_waddr] <= 1'b1;
        end
        ra1 <= o_tag_raddr;
        rd_tag <= ram_t[ra1];
        rd_v <= ram_v[ra1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return v == 32'hFFFF_FFFF ? v : v + 32'd1;
    endfunction

    task automatic clear_model;
        for (int k = 0; k < DEPTH; k++) mv[k] = 0;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic lookup(input logic [31:0] a, input int ack_dly, input bit pre_flush, input bit mid_flush);
        int ix;
        logic [TAG_W-1:0] tg;
        bit eh;
        ix = int'((a >> OFF_W) % DEPTH);
        tg = TAG_W'(a >> (OFF_W + IDX_W));
        if (pre_flush) begin
            i_flush = 1; i_req = 1; i_addr = a; #1;
            chk("pf_ready", 32'(o_ready), 0);
            step;
            chk("pf_flush_done", 32'(o_flush_done), 1);
            chk("pf_inv", 32'(o_tag_inv), 1);
            i_flush = 0;
            clear_model();
            step;
        end
        i_req = 1; i_addr = a; #1;
        chk("ready", 32'(o_ready), 1);
        chk("raddr", 32'(o_tag_raddr), 32'(ix));
        chk("clken", 32'(o_tag_clken), 1);
        eh = mv[ix] && mt[ix] == tg;
        step;
        i_req = 0; i_flush = mid_flush; #1;
        chk("rd1_done", 32'(o_done), 0);
        chk("rd1_ready", 32'(o_ready), 0);
        step; #1;
        if (eh) begin
            exp_hits = sat_inc(exp_hits);
            chk("hit_done", 32'(o_done), 1);
            chk("hit_hit", 32'(o_hit), 1);
            chk("hit_fill_req", 32'(o_fill_req), 0);
        end else begin
            exp_miss = sat_inc(exp_miss);
            chk("cmp_done", 32'(o_done), 0);
            step;
            for (int d = 0; d < ack_dly; d++) begin
                chk("fill_req_wait", 32'(o_fill_req), 1);
                step;
            end
            chk("fill_req", 32'(o_fill_req), 1);
            chk("fill_addr", o_fill_addr, a & ~32'(LINE_BYTES - 1));
            i_fill_ack = 1;
            step;
            i_fill_ack = 0; #1;
            chk("wr_wen", 32'(o_tag_wen), 1);
            chk("wr_inv", 32'(o_tag_inv), 0);
            chk("wr_waddr", 32'(o_tag_waddr), 32'(ix));
            chk("wr_wdata", 32'(o_tag_wdata), 32'(tg));
            chk("wr_done", 32'(o_done), 1);
            chk("wr_hit", 32'(o_hit), 0);
            chk("wr_fill_req", 32'(o_fill_req), 0);
            mv[ix] = 1; mt[ix] = tg;
        end
        step;
        if (mid_flush) begin
            if (!o_flush_done) step;
            chk("mf_flush_done", 32'(o_flush_done), 1);
            chk("mf_inv", 32'(o_tag_inv), 1);
            chk("mf_wen", 32'(o_tag_wen), 0);
            i_flush = 0;
            clear_model();
            step;
        end
        #1;
        chk("idle_done", 32'(o_done), 0);
        chk("idle_fill_addr", o_fill_addr, 0);
        chk("idle_wdata", 32'(o_tag_wdata), 0);
        chk("hit_cnt", o_hit_cnt, exp_hits);
        chk("miss_cnt", o_miss_cnt, exp_miss);
    endtask

    initial begin
        logic [31:0] a;
        total = 0; bad = 0; exp_hits = 0; exp_miss = 0;
        for (int k = 0; k < DEPTH; k++) begin
            ram_t[k] = '0; ram_v[k] = 1'b0;
        end
        clear_model();
        @(negedge i_clk);
        step;
        i_reset = 0; #1;
        chk("rst_ready", 32'(o_ready), 1);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_fill_req", 32'(o_fill_req), 0);
        chk("rst_hit_cnt", o_hit_cnt, 0);
        chk("rst_miss_cnt", o_miss_cnt, 0);
        lookup(32'h0000_1230, 1, 0, 0);
        lookup(32'h0000_1230, 0, 0, 0);
        lookup(32'h0000_2230, 2, 0, 0);
        lookup(32'h0000_2230, 0, 0, 1);
        lookup(32'h0000_1230, 0, 0, 0);
        chk("dir_miss_cnt", o_miss_cnt, 3);
        chk("dir_hit_cnt", o_hit_cnt, 2);
        for (int n = 0; n < 60; n++) begin
            a = ($urandom_range(0, 2) << (OFF_W + IDX_W)) | ($urandom_range(0, 3) << OFF_W) | $urandom_range(0, LINE_BYTES - 1);
            lookup(a, $urandom_range(0, 3), $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        end
        // Reset while a fill is outstanding; the late ack must be ignored.
        lookup(32'h0000_5670, 0, 1, 0);
        lookup(32'h0000_7670, 0, 0, 0);
        i_req = 1; i_addr = 32'h0000_5670;
        step;
        i_req = 0;
        step; step; #1;
        chk("rf_fill_req", 32'(o_fill_req), 1);
        i_reset = 1;
        step;
        i_reset = 0; #1;
        chk("rf_fill_req_drop", 32'(o_fill_req), 0);
        chk("rf_ready", 32'(o_ready), 1);
        step;
        i_fill_ack = 1;
        step; #1;
        chk("rf_wen", 32'(o_tag_wen), 0);
        chk("rf_done", 32'(o_done), 0);
        i_fill_ack = 0;
        step; #1;
        chk("rf_wen2", 32'(o_tag_wen), 0);
        chk("rf_hit_cnt", o_hit_cnt, 0);
        chk("rf_miss_cnt", o_miss_cnt, 0);
        exp_hits = 0; exp_miss = 0;
        // Saturation of the hit counter.
        lookup(32'h0000_1230, 0, 0, 0);
        force dut.hit_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.hit_cnt;
        exp_hits = 32'hFFFF_FFFE;
        for (int n = 0; n < 3; n++) lookup(32'h0000_1234, 0, 0, 0);
        chk("sat_hit_cnt", o_hit_cnt, 32'hFFFF_FFFF);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/zap_tag_lookup_ctrl.md
Name: zap_tag_lookup_ctrl

Overview:
Direct-mapped tag lookup and refill sequencer for cache/TLB tag arrays. Drives the read/write/invalidate port of the single-cycle-invalidate tag RAM and consumes its 2-cycle-latency read data and valid outputs. Classifies each request as hit or miss. On a miss, runs a line-fill handshake with the memory side and then writes the new tag. Also sequences bulk flush requests.

Parameters:
DEPTH, 32, number of lines; power of 2, at least 2.
LINE_BYTES, 16, bytes per line; power of 2, at least 4.
(derived) OFF_W = clog2(LINE_BYTES); IDX_W = clog2(DEPTH); TAG_W = 32-OFF_W-IDX_W.

Ports:
i_clk  in  1  clock.
i_reset  in  1  synchronous active-high reset.
i_req  in  1  lookup request, level.
i_addr  in  32  request byte address; sampled when i_req & o_ready.
o_ready  out  1  = (state==IDLE) & ~i_flush.
o_done  out  1  one-cycle pulse, lookup complete.
o_hit  out  1  valid with o_done; 1=hit, 0=miss serviced.
i_flush  in  1  flush request, level; held until o_flush_done.
o_flush_done  out  1  one-cycle pulse.
o_fill_req  out  1  line-fill request, level.
o_fill_addr  out  32  {tag,index,OFF_W'0} of the missing line.
i_fill_ack  in  1  fill complete; sampled only while o_fill_req=1.
o_tag_clken  out  1  tag RAM clock enable.
o_tag_raddr  out  IDX_W  tag RAM read address.
o_tag_waddr  out  IDX_W  tag RAM write address.
o_tag_wdata  out  TAG_W  tag RAM write data.
o_tag_wen  out  1  tag RAM write enable.
o_tag_inv  out  1  tag RAM bulk invalidate.
i_tag_rdata  in  TAG_W  tag RAM read data; 2 cycles after raddr.
i_tag_rdav  in  1  tag RAM entry valid; 2 cycles after raddr.
o_hit_cnt  out  32  hit counter.
o_miss_cnt  out  32  miss counter.

Behaviour:
- Reset (i_reset=1 at a clock edge):
  - State goes to IDLE.
  - All pulse and level outputs go to 0; counters go to 0; latched address goes to 0.
  - Reset mid-fill drops o_fill_req in the next cycle; any later i_fill_ack is ignored.
- index = addr[OFF_W +: IDX_W]; tag = addr[31 -: TAG_W].
- o_tag_clken = 1 whenever not in reset.
- o_tag_raddr: in IDLE, index of i_addr (combinational); in all other states, index of the latched address.
- States are IDLE, RD1, CMP, FILL, WR, FLUSH.
- IDLE:
  - i_flush has priority over i_req: go to FLUSH.
  - Else if i_req: latch i_addr and go to RD1 (cycle T).
- RD1: go to CMP (T+1).
- CMP (T+2):
  - Hit = i_tag_rdav & (i_tag_rdata == latched tag).
  - On hit: o_done=1, o_hit=1, o_hit_cnt++, go to IDLE. A new request is accepted no earlier than T+3, so the minimum hit-to-hit spacing is 3 cycles.
  - On miss: o_miss_cnt++, go to FILL.
- FILL:
  - o_fill_req=1 and o_fill_addr stable for the whole state.
  - On i_fill_ack=1, go to WR. Ack may arrive in the first FILL cycle.
- WR (one cycle):
  - o_tag_wen=1, o_tag_waddr = latched index, o_tag_wdata = latched tag.
  - o_done=1, o_hit=0; go to IDLE.
- FLUSH (one cycle): o_tag_inv=1, o_flush_done=1; go to IDLE. Counters are not cleared by a flush.
- Flush raised while busy: it is held pending and taken at the next IDLE. An in-flight lookup always completes first.
- If i_flush and i_req are both high in IDLE, the flush is serviced first; the request is accepted in the cycle after FLUSH, when o_ready=1.
- o_tag_wen and o_tag_inv are never asserted in the same cycle.
- Counters saturate at 32'hFFFF_FFFF; no wrap.
- o_fill_addr, o_tag_waddr and o_tag_wdata are 0 when not in use.

Test Plan:
- After reset, request i_addr=0x0000_1230 with the tag RAM returning rdav=0 → FILL with o_fill_addr=0x0000_1230. After ack: one WR cycle with waddr=3, wdata=0x000009; o_done=1, o_hit=0; o_miss_cnt=1.
- Repeat 0x0000_1230 with RAM returning rdata=0x000009, rdav=1 → o_done and o_hit at T+2; o_hit_cnt=1; o_fill_req never asserted.
- Request 0x0000_2230 (same index 3, tag 0x000011) against stored tag 0x000009 → miss. o_fill_addr=0x0000_2230; WR writes wdata=0x000011.
- Assert i_flush in cycle T+1 of a lookup → the lookup completes with o_done. FLUSH follows in the next cycle with o_tag_inv=1 and o_flush_done=1. A subsequent lookup of 0x0000_1230 misses.
- Assert i_reset for one cycle while in FILL, with ack arriving 2 cycles later → o_fill_req=0 the cycle after reset; no WR occurs, o_done stays 0, both counters read 0.
- Preload o_hit_cnt=0xFFFF_FFFE by forcing, then perform 3 hits → counter reads 0xFFFF_FFFF and holds.
